// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN sequencer slice.
package gcn_pkg;

  localparam int unsigned GCN_N_NODE = 100;
  localparam int unsigned GCN_N_WCOL = 8;
  localparam int unsigned GCN_DW     = 16;
  localparam int unsigned GCN_AW     = 12;

  localparam logic SEL_FEAT = 1'b0;
  localparam logic SEL_WGT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    LOAD,
    CMP,
    OUT_HDR,
    OUT
  } state_t;

  // Request header word 0: two weight-column indices.
  typedef struct packed {
    logic [7:0] col2;
    logic [7:0] col1;
  } hdr_t;

endpackage

// File: rtl/gcn_res_fifo.sv
// Synchronous FIFO (arbitrary depth) with pointer wrap and occupancy count.
module gcn_res_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr     = wr_en && (count != CW'(DEPTH));
  assign do_rd     = rd_en && (count != '0);
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap at DEPTH-1 since DEPTH need not be a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : PW'(wr_ptr + PW'(1));
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : PW'(rd_ptr + PW'(1));
      case ({do_wr, do_rd})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcn_seq_ctrl.sv
// GCN request sequencer: header parse, buffer load, two PE passes, result streaming.
// Optional ReLU on captured results when GCN_SEQ_RELU_EN is defined.
module gcn_seq_ctrl
  import gcn_pkg::*;
#(
  parameter int unsigned N_NODE = GCN_N_NODE,
  parameter int unsigned N_WCOL = GCN_N_WCOL,
  parameter int unsigned DW     = GCN_DW,
  parameter int unsigned AW     = GCN_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_cmd,
  input  logic [DW-1:0] i_data,
  output logic          o_stall,
  output logic          o_wr_en,
  output logic          o_wr_sel,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_pe_start,
  output logic [6:0]    o_pe_row,
  output logic [7:0]    o_pe_col,
  input  logic          i_pe_done,
  input  logic [DW-1:0] i_pe_res,
  output logic          o_rdy,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_err
);

  localparam int unsigned ROW_W = 7;
  localparam int unsigned COL_W = 8;
  localparam int unsigned DEPTH = 2 * N_NODE;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_t          state_q, state_n;
  hdr_t            hdr_q, hdr_n;
  logic [AW-1:0]   len_q, len_n;
  logic [AW-1:0]   load_cnt_q, load_cnt_n;
  logic [AW-1:0]   waddr_feat_q, waddr_feat_n;
  logic [AW-1:0]   waddr_wgt_q, waddr_wgt_n;
  logic            pass_q, pass_n;
  logic [ROW_W-1:0] row_q, row_n;
  logic            busy_q, busy_n;

  logic            stall_n, wr_en_n, wr_sel_n, pe_start_n, rdy_n, valid_n, err_n;
  logic [AW-1:0]   wr_addr_n;
  logic [DW-1:0]   wr_data_n, data_n;
  logic [ROW_W-1:0] pe_row_n;
  logic [COL_W-1:0] pe_col_n;

  logic            fifo_wr_c, fifo_rd_c;
  logic [DW-1:0]   res_c, fifo_rd_data_c;
  logic [CNT_W-1:0] fifo_cnt;

  logic [COL_W-1:0] raw_col1_c, raw_col2_c;
  logic            bad_col1_c, bad_col2_c;

  assign raw_col1_c = i_data[7:0];
  assign raw_col2_c = i_data[15:8];
  assign bad_col1_c = raw_col1_c >= COL_W'(N_WCOL);
  assign bad_col2_c = raw_col2_c >= COL_W'(N_WCOL);

  // Result conditioning ahead of the FIFO.
  always_comb begin
    res_c = i_pe_res;
`ifdef GCN_SEQ_RELU_EN
    if (i_pe_res[DW-1]) res_c = '0;
`else
`endif
  end

  gcn_res_fifo #(.DW(DW), .DEPTH(DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fifo_wr_c),
    .wr_data   (res_c),
    .rd_en     (fifo_rd_c),
    .rd_data_c (fifo_rd_data_c),
    .count     (fifo_cnt)
  );

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n      = state_q;
    hdr_n        = hdr_q;
    len_n        = len_q;
    load_cnt_n   = load_cnt_q;
    waddr_feat_n = waddr_feat_q;
    waddr_wgt_n  = waddr_wgt_q;
    pass_n       = pass_q;
    row_n        = row_q;
    busy_n       = busy_q;
    err_n        = o_err;
    wr_en_n      = 1'b0;
    wr_sel_n     = o_wr_sel;
    wr_addr_n    = o_wr_addr;
    wr_data_n    = o_wr_data;
    pe_start_n   = 1'b0;
    pe_row_n     = o_pe_row;
    pe_col_n     = o_pe_col;
    rdy_n        = 1'b0;
    valid_n      = 1'b0;
    data_n       = o_data;
    fifo_wr_c    = 1'b0;
    fifo_rd_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          hdr_n.col1   = bad_col1_c ? '0 : raw_col1_c;
          hdr_n.col2   = bad_col2_c ? '0 : raw_col2_c;
          err_n        = bad_col1_c || bad_col2_c;
          waddr_feat_n = '0;
          waddr_wgt_n  = '0;
          state_n      = HDR1;
        end
      end
      HDR1: begin
        if (i_req) begin
          len_n      = i_data[AW-1:0];
          load_cnt_n = '0;
          pass_n     = 1'b0;
          row_n      = '0;
          busy_n     = 1'b0;
          state_n    = (i_data[AW-1:0] == '0) ? CMP : LOAD;
        end
      end
      LOAD: begin
        wr_en_n    = 1'b1;
        wr_sel_n   = i_cmd;
        wr_data_n  = i_data;
        if (i_cmd == SEL_WGT) begin
          wr_addr_n   = waddr_wgt_q;
          waddr_wgt_n = AW'(waddr_wgt_q + AW'(1));
        end else begin
          wr_addr_n    = waddr_feat_q;
          waddr_feat_n = AW'(waddr_feat_q + AW'(1));
        end
        load_cnt_n = AW'(load_cnt_q + AW'(1));
        if (load_cnt_q == AW'(len_q - AW'(1))) state_n = CMP;
      end
      CMP: begin
        // One job in flight; the follow-on start is issued on the done cycle.
        if (!busy_q) begin
          pe_start_n = 1'b1;
          pe_row_n   = row_q;
          pe_col_n   = pass_q ? hdr_q.col2 : hdr_q.col1;
          busy_n     = 1'b1;
        end else if (i_pe_done) begin
          fifo_wr_c = 1'b1;
          if (row_q == ROW_W'(N_NODE - 1)) begin
            if (pass_q) begin
              busy_n  = 1'b0;
              state_n = OUT_HDR;
            end else begin
              pass_n     = 1'b1;
              row_n      = '0;
              pe_start_n = 1'b1;
              pe_row_n   = '0;
              pe_col_n   = hdr_q.col2;
            end
          end else begin
            row_n      = ROW_W'(row_q + ROW_W'(1));
            pe_start_n = 1'b1;
            pe_row_n   = ROW_W'(row_q + ROW_W'(1));
            pe_col_n   = pass_q ? hdr_q.col2 : hdr_q.col1;
          end
        end
      end
      OUT_HDR: begin
        rdy_n   = 1'b1;
        valid_n = 1'b1;
        data_n  = DW'(hdr_q);
        state_n = OUT;
      end
      OUT: begin
        rdy_n     = 1'b1;
        valid_n   = 1'b1;
        data_n    = fifo_rd_data_c;
        fifo_rd_c = 1'b1;
        if (fifo_cnt == CNT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    stall_n = (state_n == CMP) || (state_n == OUT_HDR) || (state_n == OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hdr_q        <= '0;
      len_q        <= '0;
      load_cnt_q   <= '0;
      waddr_feat_q <= '0;
      waddr_wgt_q  <= '0;
      pass_q       <= 1'b0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      o_stall      <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_sel     <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_pe_start   <= 1'b0;
      o_pe_row     <= '0;
      o_pe_col     <= '0;
      o_rdy        <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_err        <= 1'b0;
    end else begin
      state_q      <= state_n;
      hdr_q        <= hdr_n;
      len_q        <= len_n;
      load_cnt_q   <= load_cnt_n;
      waddr_feat_q <= waddr_feat_n;
      waddr_wgt_q  <= waddr_wgt_n;
      pass_q       <= pass_n;
      row_q        <= row_n;
      busy_q       <= busy_n;
      o_stall      <= stall_n;
      o_wr_en      <= wr_en_n;
      o_wr_sel     <= wr_sel_n;
      o_wr_addr    <= wr_addr_n;
      o_wr_data    <= wr_data_n;
      o_pe_start   <= pe_start_n;
      o_pe_row     <= pe_row_n;
      o_pe_col     <= pe_col_n;
      o_rdy        <= rdy_n;
      o_valid      <= valid_n;
      o_data       <= data_n;
      o_err        <= err_n;
    end
  end

endmodule

// File: doc/gcn_seq_ctrl.md
Name: gcn_seq_ctrl

Overview:
- Top-level sequencer for the GCN accelerator. It sits between the serial 16-bit host port and the buffer/PE datapath.
- Parses a two-word request header, then steers the payload stream into the feature and weight buffers.
- Runs two compute passes (weight column col1, then col2) over all nodes on the PE.
- Streams the column header and 2*N_NODE results back to the host.

Parameters:
- N_NODE, 100, nodes per pass (output rows per column)
- N_WCOL, 8, number of weight columns; col index must be < N_WCOL
- DW, 16, data word width
- AW, 12, buffer address width (covers the longest payload)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  header qualifier; high on header words 0 and 1
- i_cmd  in  1  payload target: 0 = feature/adjacency buffer, 1 = weight buffer
- i_data  in  DW  host input word
- o_stall  out  1  high = input word not accepted this cycle
- o_wr_en  out  1  buffer write strobe
- o_wr_sel  out  1  buffer select (copy of i_cmd)
- o_wr_addr  out  AW  per-buffer auto-increment address
- o_wr_data  out  DW  write data
- o_pe_start  out  1  one-cycle PE job launch
- o_pe_row  out  7  node index for the job
- o_pe_col  out  8  weight column for the job
- i_pe_done  in  1  one-cycle job completion
- i_pe_res  in  DW  result, valid with i_pe_done
- o_rdy  out  1  high for the whole output phase
- o_valid  out  1  o_data valid this cycle
- o_data  out  DW  header word or result
- o_err  out  1  sticky: column index out of range in the last request

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0 except o_stall=0; counters and both write addresses cleared.
- States: IDLE -> HDR1 -> LOAD -> CMP -> OUT_HDR -> OUT -> IDLE.
- IDLE:
  - Accepts i_data when i_req=1.
  - Latches {col2,col1} = i_data[15:8], i_data[7:0]; goes to HDR1.
  - Words with i_req=0 are ignored.
- HDR1:
  - Next word with i_req=1 latches payload length L (i_data[AW-1:0]).
  - L=0 goes directly to CMP; otherwise goes to LOAD.
- LOAD:
  - Each cycle one word is accepted.
  - o_wr_en=1 one cycle after acceptance (1-cycle registered latency).
  - o_wr_addr comes from an independent counter per i_cmd value, each starting at 0.
  - After L words, goes to CMP.
  - i_req in LOAD is ignored (treated as payload).
- o_stall: 0 in IDLE/HDR1/LOAD; 1 in CMP/OUT_HDR/OUT. Host words presented while stalled are dropped.
- Column range check: if col1 or col2 >= N_WCOL, that column is replaced by 0 and o_err is set. o_err clears on the next accepted header word 0.
- CMP:
  - Pass p=0 uses col1, pass p=1 uses col2.
  - For row r = 0..N_NODE-1: pulse o_pe_start with o_pe_row=r and o_pe_col set for the pass.
  - Wait for i_pe_done, capture i_pe_res into the result FIFO; the next start follows one cycle after done.
  - At most one job is outstanding. i_pe_done with no job outstanding is ignored.
  - After the last row of pass 1, goes to OUT_HDR.
- Result FIFO: 2*N_NODE deep, implemented as a simple dual-port array with read and write pointers.
- OUT_HDR: o_rdy=1, o_valid=1, o_data={col2,col1} for exactly 1 cycle.
- OUT:
  - o_rdy=1, o_valid=1 each cycle.
  - Order: rows 0..N_NODE-1 of col1, then rows 0..N_NODE-1 of col2, back-to-back with no bubbles.
  - After the final word: o_rdy=0, o_valid=0, state IDLE.
- Total output: 1 + 2*N_NODE valid words.
- Reset asserted mid-operation: FSM returns to IDLE immediately; FIFO pointers cleared; no partial output is emitted afterwards.

Optional Feature:
- Macro GCN_SEQ_RELU_EN.
- When defined: each captured result is passed through ReLU before entering the FIFO (two's complement: sign bit 1 -> 0x0000).
- When undefined: results pass unmodified.
- Header word is never modified either way.

Decomposition:
- Shared package gcn_pkg holds:
  - state encoding constants (IDLE, HDR1, LOAD, CMP, OUT_HDR, OUT)
  - default N_NODE, N_WCOL, DW
  - buffer-select codes SEL_FEAT=0, SEL_WGT=1
- One sub-module: gcn_res_fifo, a parameterised synchronous FIFO with write/read pointers and count. It is reused by the output stage.

Test Plan:
- Reset with a header applied: rst low for 2 cycles while i_req=1 -> all outputs 0, state IDLE, nothing latched.
- Basic load:
  - Stimulus: header 0x0302, L=4, payload cmd pattern 0,1,0,1 with data 0xA..0xD.
  - Expected writes: (sel0,addr0,0xA), (sel1,addr0,0xB), (sel0,addr1,0xC), (sel1,addr1,0xD).
  - Then first o_pe_start has row 0, col 2.
- Full run:
  - PE model returns row*16+col after a random 1..5-cycle latency.
  - Output: 0x0302, then 2,18,...,1586 (col 2, rows 0..99), then 3,...,1587 (col 3, rows 0..99).
  - 201 valid words total, contiguous, o_rdy high throughout.
- Out-of-range column: header 0x0009 -> o_err=1; both passes use col 0; header out is 0x0000.
- ReLU variant: with GCN_SEQ_RELU_EN, PE returns 0xFFF0 -> output 0x0000. Without the macro -> output 0xFFF0.
- Mid-compute reset:
  - Stimulus: rst pulsed low at row 50 of pass 0.
  - Expected: no o_valid afterwards.
  - A new request then completes normally with 201 correct words.
